// File: rtl/pipelined_adder_if.sv
// ---------------------------------------------------------------------------
// pipelined_adder_if
// Operand/result handshake bundle for pipelined_adder.
//   x, y, cIn   : operands and carry-in (producer -> adder)
//   inValid     : operand set valid      (producer -> adder)
//   inReady     : adder accepts operands (adder -> producer)
//   sum, cOut   : result and carry-out   (adder -> consumer)
//   outValid    : result valid           (adder -> consumer)
//   outReady    : consumer takes result  (consumer -> adder)
// The WIDTH given here must match the WIDTH of the attached pipelined_adder.
// ---------------------------------------------------------------------------
interface pipelined_adder_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             cIn;
    logic             inValid;
    logic             inReady;
    logic [WIDTH-1:0] sum;
    logic             cOut;
    logic             outValid;
    logic             outReady;

    // master: the side that supplies operands and consumes results
    modport master (
        output x, y, cIn, inValid, outReady,
        input  inReady, sum, cOut, outValid
    );

    // slave: the adder itself
    modport slave (
        input  x, y, cIn, inValid, outReady,
        output inReady, sum, cOut, outValid
    );
endinterface

// File: rtl/pipelined_adder.sv
// ---------------------------------------------------------------------------
// pipelined_adder
// WIDTH-bit adder split into STAGES ripple-carry chunks of CHUNK bits, one
// chunk per pipeline stage, with a valid/ready handshake on both sides.
// Latency is STAGES cycles; throughput is one result per cycle.
//   clk   : clock, rising edge
//   rstN  : asynchronous active-low reset, clears all stage state
//   bus   : pipelined_adder_if.slave (operands in, sum/cOut out, handshakes)
// WIDTH must be an integer multiple of STAGES.
// ---------------------------------------------------------------------------
module pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic              clk,
    input  logic              rstN,
    pipelined_adder_if.slave  bus
);
    localparam int CHUNK = WIDTH / STAGES;

    // Stage registers. Stage k holds: sum bits [0 .. (k+1)*CHUNK-1] already
    // computed (upper bits zero), the carry out of chunk k, and the full
    // operand words so the next stage can pick its own chunk.
    logic [STAGES-1:0]            r_v;
    logic [STAGES-1:0]            r_c;
    logic [STAGES-1:0][WIDTH-1:0] r_x;
    logic [STAGES-1:0][WIDTH-1:0] r_y;
    logic [STAGES-1:0][WIDTH-1:0] r_sum;

    // What each stage sees at its input (stage 0: the bus, stage k: reg k-1)
    logic [STAGES-1:0]            w_src_v;
    logic [STAGES-1:0]            w_src_c;
    logic [STAGES-1:0][WIDTH-1:0] w_src_x;
    logic [STAGES-1:0][WIDTH-1:0] w_src_y;
    logic [STAGES-1:0][WIDTH-1:0] w_src_sum;
    logic [STAGES-1:0][WIDTH-1:0] w_sum_next;

    logic [STAGES-1:0][CHUNK-1:0] w_fa_s;   // chunk sum of each stage
    logic [STAGES-1:0]            w_fa_co;  // chunk carry-out of each stage
    logic [STAGES-1:0]            w_ld;     // stage load enables
    logic                         w_unused;

    always_comb begin
        // Operands are forced to zero when not valid so idle cycles do not
        // depend on whatever is parked on the bus.
        w_src_v[0]   = bus.inValid;
        w_src_c[0]   = bus.cIn & bus.inValid;
        w_src_x[0]   = bus.inValid ? bus.x : '0;
        w_src_y[0]   = bus.inValid ? bus.y : '0;
        w_src_sum[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            w_src_v[k]   = r_v[k-1];
            w_src_c[k]   = r_c[k-1];
            w_src_x[k]   = r_x[k-1];
            w_src_y[k]   = r_y[k-1];
            w_src_sum[k] = r_sum[k-1];
        end
    end

    // Splice each stage's fresh chunk into the forwarded partial sum.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            w_sum_next[k]                  = w_src_sum[k];
            w_sum_next[k][k*CHUNK +: CHUNK] = w_fa_s[k];
        end
    end

    genvar gi, gj;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            // Stage gi loads when it or any stage downstream of it has room,
            // or the consumer drains the last stage. Written in this
            // unrolled form so no bit of w_ld depends on another bit.
            assign w_ld[gi] = bus.outReady | ~(&r_v[STAGES-1:gi]);

            // CHUNK-bit ripple chain of full adders
            for (gj = 0; gj < CHUNK; gj++) begin : g_bit
                logic w_a;
                logic w_b;
                logic w_ci;
                logic w_co;
                assign w_a = w_src_x[gi][gi*CHUNK + gj];
                assign w_b = w_src_y[gi][gi*CHUNK + gj];
                if (gj == 0) begin : g_first
                    assign w_ci = w_src_c[gi];
                end else begin : g_next
                    assign w_ci = g_bit[gj-1].w_co;
                end
                assign w_fa_s[gi][gj] = w_a ^ w_b ^ w_ci;
                assign w_co           = (w_a & w_b) | (w_a & w_ci) | (w_b & w_ci);
            end
            assign w_fa_co[gi] = g_bit[CHUNK-1].w_co;
        end
    endgenerate

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_v   <= '0;
            r_c   <= '0;
            r_x   <= '0;
            r_y   <= '0;
            r_sum <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_ld[k]) begin
                    r_v[k] <= w_src_v[k];
                    // Data only moves with a valid transaction; a bubble
                    // just clears the valid bit.
                    if (w_src_v[k]) begin
                        r_x[k]   <= w_src_x[k];
                        r_y[k]   <= w_src_y[k];
                        r_sum[k] <= w_sum_next[k];
                        r_c[k]   <= w_fa_co[k];
                    end
                end
            end
        end
    end

    assign bus.inReady  = w_ld[0];
    assign bus.sum      = r_sum[STAGES-1];
    assign bus.cOut     = r_c[STAGES-1];
    assign bus.outValid = r_v[STAGES-1];

    // Operand bits below the current chunk (and all of the last stage's
    // operands) are never consumed; fold them here so they are not dangling.
    assign w_unused = ^{r_x, r_y};

endmodule

// File: tb/tb_pipelined_adder.sv
`timescale 1ns/1ps
module tb_pipelined_adder;
    localparam int N_RND = 10000;

    logic clk  = 1'b0;
    logic rstN = 1'b0;
    int   n_chk = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    pipelined_adder_if #(.WIDTH(16)) bus();

    pipelined_adder #(.WIDTH(16), .STAGES(4)) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b, input logic c);
        bus.inValid = v;
        bus.x       = a;
        bus.y       = b;
        bus.cIn     = c;
    endtask

    function automatic logic [16:0] ref_add(input logic [15:0] a, input logic [15:0] b, input logic c);
        return {1'b0, a} + {1'b0, b} + {16'd0, c};
    endfunction

    // One isolated transaction into an empty pipe: checks acceptance,
    // 4-edge latency and the result, then drains it.
    task automatic send_one(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic c, input logic [16:0] exp);
        int lat;
        drive(1'b1, a, b, c);
        bus.outReady = 1'b1;
        check({tag, "_rdy"}, 32'(bus.inReady), 32'd1);
        tick;
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        lat = 1;
        while (!bus.outValid && lat < 20) begin
            tick;
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'd4);
        check({tag, "_res"}, 32'({bus.cOut, bus.sum}), 32'(exp));
        $display("txn %s: %h + %h + %0d -> %h c%0d", tag, a, b, c, bus.sum, bus.cOut);
        tick;
        check({tag, "_gone"}, 32'(bus.outValid), 32'd0);
    endtask

    // Stall test vectors with hand-computed results {cOut,sum}
    logic [15:0] sx [5] = '{16'h1111, 16'h0F0F, 16'hFFFE, 16'hABCD, 16'h8001};
    logic [15:0] sy [5] = '{16'h2222, 16'h00F1, 16'h0001, 16'h1234, 16'h8001};
    logic        sc [5] = '{1'b0,     1'b0,     1'b1,     1'b1,     1'b0};
    logic [16:0] se [5] = '{17'h03333, 17'h01000, 17'h10000, 17'h0BE02, 17'h10002};

    // Chunk-boundary carries, hand-computed
    logic [15:0] bx [6] = '{16'h000F, 16'h00FF, 16'h0FFF, 16'h0000, 16'h7FFF, 16'hFFFF};
    logic [15:0] by [6] = '{16'h0001, 16'h0001, 16'h0001, 16'h0000, 16'h0001, 16'h0000};
    logic        bc [6] = '{1'b0,     1'b0,     1'b0,     1'b1,     1'b0,     1'b1};
    logic [16:0] be [6] = '{17'h00010, 17'h00100, 17'h01000, 17'h00001, 17'h08000, 17'h10000};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        int          acc;
        int          sent;
        int          recv;
        int          cyc;
        logic [15:0] ca, cb;
        logic        cc;
        logic [16:0] e;
        logic [16:0] exp_q [$];

        drive(1'b0, 16'h0, 16'h0, 1'b0);
        bus.outReady = 1'b0;
        rstN = 1'b0;
        #1;
        check("rst_ov",  32'(bus.outValid), 32'd0);
        check("rst_sum", 32'(bus.sum),      32'd0);
        check("rst_co",  32'(bus.cOut),     32'd0);
        check("rst_rdy", 32'(bus.inReady),  32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
        #1;
        check("rel_rdy", 32'(bus.inReady), 32'd1);
        tick;

        // Full carry ripple through every chunk
        send_one("max", 16'hFFFF, 16'h0001, 1'b0, 17'h10000);

        for (int i = 0; i < 6; i++)
            send_one($sformatf("bnd%0d", i), bx[i], by[i], bc[i], be[i]);

        // Back-to-back transactions, results on consecutive cycles
        bus.outReady = 1'b1;
        drive(1'b1, 16'h1234, 16'h4321, 1'b1);
        tick;
        drive(1'b1, 16'h8000, 16'h8000, 1'b0);
        tick;
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        tick;
        tick;
        check("b2b_v1", 32'(bus.outValid), 32'd1);
        check("b2b_r1", 32'({bus.cOut, bus.sum}), 32'h05556);
        $display("txn b2b1: 1234 + 4321 + 1 -> %h c%0d", bus.sum, bus.cOut);
        tick;
        check("b2b_v2", 32'(bus.outValid), 32'd1);
        check("b2b_r2", 32'({bus.cOut, bus.sum}), 32'h10000);
        $display("txn b2b2: 8000 + 8000 + 0 -> %h c%0d", bus.sum, bus.cOut);
        tick;
        check("b2b_end", 32'(bus.outValid), 32'd0);

        // Stall: consumer blocked, producer always valid
        bus.outReady = 1'b0;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, sx[acc > 4 ? 4 : acc], sy[acc > 4 ? 4 : acc], sc[acc > 4 ? 4 : acc]);
            if (bus.inReady) acc++;
            tick;
        end
        check("stall_cnt", 32'(acc), 32'd4);
        check("stall_rdy", 32'(bus.inReady), 32'd0);
        check("stall_ov",  32'(bus.outValid), 32'd1);
        check("stall_h0",  32'({bus.cOut, bus.sum}), 32'(se[0]));
        tick;
        tick;
        check("stall_ov2", 32'(bus.outValid), 32'd1);
        check("stall_h1",  32'({bus.cOut, bus.sum}), 32'(se[0]));
        // Drain while a fifth transaction enters in the same cycle
        drive(1'b1, sx[4], sy[4], sc[4]);
        bus.outReady = 1'b1;
        #1;
        check("drain_rdy", 32'(bus.inReady), 32'd1);
        $display("txn stall0: %h + %h + %0d -> %h c%0d", sx[0], sy[0], sc[0], bus.sum, bus.cOut);
        tick;
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        for (int i = 1; i < 5; i++) begin
            check($sformatf("drain_v%0d", i), 32'(bus.outValid), 32'd1);
            check($sformatf("drain_r%0d", i), 32'({bus.cOut, bus.sum}), 32'(se[i]));
            $display("txn stall%0d: %h + %h + %0d -> %h c%0d", i, sx[i], sy[i], sc[i], bus.sum, bus.cOut);
            tick;
        end
        check("drain_end", 32'(bus.outValid), 32'd0);

        // Reset with three transactions in flight
        bus.outReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, sx[i], sy[i], sc[i]);
            tick;
        end
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        #2;
        rstN = 1'b0;
        #1;
        check("mrst_ov",  32'(bus.outValid), 32'd0);
        check("mrst_sum", 32'(bus.sum),      32'd0);
        check("mrst_rdy", 32'(bus.inReady),  32'd1);
        @(negedge clk);
        rstN = 1'b1;
        tick;
        bus.outReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stale%0d", i), 32'(bus.outValid), 32'd0);
            tick;
        end
        send_one("post_rst", 16'h00FF, 16'h0001, 1'b0, 17'h00100);

        // Random traffic against a scoreboard, boundary vectors first
        sent = 0;
        recv = 0;
        cyc  = 0;
        ca = bx[0]; cb = by[0]; cc = bc[0];
        while (recv < N_RND && cyc < 60000) begin
            bus.inValid  = (sent < N_RND) && ($urandom_range(0, 3) != 0);
            bus.x        = ca;
            bus.y        = cb;
            bus.cIn      = cc;
            bus.outReady = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (bus.outValid && bus.outReady) begin
                if (exp_q.size() == 0) begin
                    check("rnd_extra", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rnd", 32'({bus.cOut, bus.sum}), 32'(e));
                    $display("txn rnd%0d: -> %h c%0d (want %h)", recv, bus.sum, bus.cOut, e);
                end
                recv++;
            end
            if (bus.inValid && bus.inReady) begin
                exp_q.push_back(ref_add(ca, cb, cc));
                sent++;
                if (sent < 6) begin
                    ca = bx[sent]; cb = by[sent]; cc = bc[sent];
                end else begin
                    ca = 16'($urandom);
                    cb = 16'($urandom);
                    cc = 1'($urandom);
                end
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        check("rnd_count", 32'(recv), 32'(N_RND));
        check("rnd_left",  32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the operand and sum width in bits.
REQ-002 SHALL have parameter STAGES, default 4, giving the pipeline depth; WIDTH SHALL be an integer multiple of STAGES; CHUNK = WIDTH/STAGES.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rstN, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port x, input, WIDTH bits: operand A.
REQ-006 SHALL have port y, input, WIDTH bits: operand B.
REQ-007 SHALL have port cIn, input, 1 bit: carry-in for bit 0.
REQ-008 SHALL have port inValid, input, 1 bit: x, y and cIn are valid.
REQ-009 SHALL have port inReady, output, 1 bit: the block accepts an operand set this cycle.
REQ-010 SHALL have port sum, output, WIDTH bits: registered result x+y+cIn modulo 2^WIDTH.
REQ-011 SHALL have port cOut, output, 1 bit: carry out of bit WIDTH-1.
REQ-012 SHALL have port outValid, output, 1 bit: sum and cOut are valid.
REQ-013 SHALL have port outReady, input, 1 bit: the consumer accepts the result this cycle.

Function
REQ-014 SHALL build each stage k (0..STAGES-1) from a CHUNK-bit ripple chain of full-adder cells (sum = a^b^c; carry = majority(a,b,c)) adding operand bits [k*CHUNK +: CHUNK].
REQ-015 SHALL register the carry out of stage k and use it as the carry-in of stage k+1 for the same transaction; stage 0 SHALL use the accepted cIn.
REQ-016 SHALL carry unconsumed operand slices forward with the transaction (input skew).
REQ-017 SHALL carry already-computed sum slices forward until all slices are complete (output deskew), so that sum and cOut are presented together.
REQ-018 SHALL give each stage register a valid bit v[k]; the last stage register drives sum, cOut and outValid.
REQ-019 SHALL let stage k load when v[k]==0 or stage k+1 loads that cycle; the last stage SHALL load when outValid==0 or outReady==1.
REQ-020 SHALL drive inReady combinationally as the stage-0 load condition; an input transfer SHALL occur on inValid && inReady.
REQ-021 SHALL clear v[k] when stage k empties and its predecessor holds no valid data.
REQ-022 SHALL have latency STAGES cycles: an operand set accepted at edge n SHALL appear with outValid=1 after edge n+STAGES-1, given no stall.
REQ-023 SHALL sustain throughput of one result per cycle when outReady is held at 1.
REQ-024 SHALL hold sum, cOut and outValid stable while outValid==1 and outReady==0.
REQ-025 SHALL allow at most STAGES transactions in flight; when full and stalled, inReady SHALL be 0.
REQ-026 SHALL allow a full pipe with outReady=1 to accept a new input in the same cycle the oldest result drains.
REQ-027 SHALL preserve transaction order and SHALL never drop or duplicate a transaction.
REQ-028 SHALL ignore x, y and cIn when inValid==0.

Reset
REQ-029 SHALL, while rstN==0 and independent of clk, clear all v[k], outValid, sum, cOut and all pipeline data and carry registers to 0.
REQ-030 SHALL discard in-flight transactions on reset mid-operation; the first result after reset SHALL come from the first input accepted after rstN deasserts.
REQ-031 SHALL drive inReady=1 during and immediately after reset.

Verification
REQ-032 SHALL check, with defaults: x=16'hFFFF, y=16'h0001, cIn=0, outReady=1 -> sum=16'h0000, cOut=1 with outValid after 4 edges.
REQ-033 SHALL check back-to-back inputs (16'h1234+16'h4321, cIn=1) then (16'h8000+16'h8000, cIn=0) on consecutive cycles -> sum=16'h5556, cOut=0, then sum=16'h0000, cOut=1 on consecutive cycles.
REQ-034 SHALL check stall: outReady=0 with inValid=1 continuously -> exactly 4 accepted, inReady=0, output held; outReady=1 -> 4 ordered results, one per cycle, with a new input accepted during drain.
REQ-035 SHALL check reset with 3 transactions in flight: rstN=0 -> outValid=0, sum=0 immediately; no stale result after release.
REQ-036 SHALL check a random compare of 10k transactions with random inValid/outReady against the reference x+y+cIn, including carry across every chunk boundary (e.g. 16'h00FF+16'h0001 -> 16'h0100).
